// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-vector helpers for the header merge packer.
// Keep vectors are zero-extended to MaxBytes so one set of helpers serves any bus width.
package axis_hdr_pkg;

    localparam int unsigned MaxBytes = 64;

    typedef logic [MaxBytes-1:0] keep_t;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush
    } state_e;

    function automatic keep_t cnt_to_keep_lsb(int unsigned cnt);
        return (cnt >= MaxBytes) ? '1 : ((keep_t'(1) << cnt) - keep_t'(1));
    endfunction

    function automatic keep_t cnt_to_keep_msb(int unsigned cnt, int unsigned n);
        return cnt_to_keep_lsb(cnt) << (n - cnt);
    endfunction

    // Count of consecutive ones starting at bit n-1 going down.
    function automatic int unsigned lead_ones(keep_t keep, int unsigned n);
        int unsigned cnt;
        logic        run;
        keep_t       sh;
        cnt = 0;
        run = 1'b1;
        for (int unsigned j = 0; j < MaxBytes; j++) begin
            if (j < n) begin
                sh = keep >> (n - 1 - j);
                if (run && sh[0]) cnt++;
                else run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic int unsigned trail_ones(keep_t keep, int unsigned n);
        int unsigned cnt;
        logic        run;
        keep_t       sh;
        cnt = 0;
        run = 1'b1;
        for (int unsigned j = 0; j < MaxBytes; j++) begin
            if (j < n) begin
                sh = keep >> j;
                if (run && sh[0]) cnt++;
                else run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic logic msb_contig(keep_t keep, int unsigned n);
        return keep == cnt_to_keep_msb(lead_ones(keep, n), n);
    endfunction

    function automatic logic lsb_contig(keep_t keep, int unsigned n);
        return keep == cnt_to_keep_lsb(trail_ones(keep, n));
    endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-deep registered output stage; adv says the register may take a new beat this cycle.
module axis_out_slice #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [DATA_WD-1:0]      load_data,
    input  logic [DATA_BYTE_WD-1:0] load_keep,
    input  logic                    load_last,
    output logic                    adv,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    logic                    valid_q;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic                    last_q;

    assign adv = !valid_q || ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= load_valid;
            data_q  <= load_data;
            keep_q  <= load_keep;
            last_q  <= load_last;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

endmodule

// File: rtl/axis_header_merge_packer.sv
// Prepends a 0..N byte header to each AXI-Stream packet and repacks the payload gap-free.
// Residue bytes are held MSB-aligned; each payload beat is barrel-shifted in right behind them.
module axis_header_merge_packer
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned CNT_WD       = $clog2(DATA_BYTE_WD + 1),
    parameter int unsigned PKT_CNT_WD   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    err_keep,
    output logic [PKT_CNT_WD-1:0]   pkt_cnt
);

    localparam int unsigned NumBytes = DATA_BYTE_WD;
    localparam int unsigned WinWd    = 2 * DATA_WD;
    localparam logic [CNT_WD:0] NFull = (CNT_WD + 1)'(NumBytes);

    state_e                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CNT_WD-1:0]       r_q, r_d;
    logic                    err_q, err_d;
    logic [PKT_CNT_WD-1:0]   pkt_q;

    logic                    adv, acc_hdr, acc_pay, hdr_bad, pay_bad;
    logic [CNT_WD-1:0]       h_cnt, k_cnt, r_after;
    logic [CNT_WD:0]         t_cnt;
    logic [NumBytes-1:0]     hk, pk, tk, rk;
    logic [DATA_WD-1:0]      hdr_mask, pay_mask;
    logic [WinWd-1:0]        pay_ext, win;

    logic                    ld_valid, ld_last;
    logic [DATA_WD-1:0]      ld_data;
    logic [NumBytes-1:0]     ld_keep;

    assign ready_insert = !rst && (state_q == StIdle);
    assign ready_in     = !rst && (state_q == StStream) && adv;
    assign acc_hdr      = valid_insert && ready_insert;
    assign acc_pay      = valid_in && ready_in;

    assign h_cnt   = CNT_WD'(trail_ones(keep_t'(keep_insert), NumBytes));
    assign k_cnt   = CNT_WD'(lead_ones(keep_t'(keep_in), NumBytes));
    assign t_cnt   = {1'b0, r_q} + {1'b0, k_cnt};
    assign r_after = (t_cnt >= NFull) ? CNT_WD'(t_cnt - NFull) : '0;

    assign hdr_bad = !lsb_contig(keep_t'(keep_insert), NumBytes);
    assign pay_bad = !msb_contig(keep_t'(keep_in), NumBytes) || (keep_in == '0) ||
                     (!last_in && (keep_in != '1));

    assign hk = NumBytes'(cnt_to_keep_lsb(32'(h_cnt)));
    assign pk = NumBytes'(cnt_to_keep_msb(32'(k_cnt), NumBytes));
    assign tk = NumBytes'(cnt_to_keep_msb(32'(t_cnt), NumBytes));
    assign rk = NumBytes'(cnt_to_keep_msb(32'(r_q), NumBytes));

    for (genvar b = 0; b < NumBytes; b++) begin : g_mask
        assign hdr_mask[8*b +: 8] = {8{hk[b]}};
        assign pay_mask[8*b +: 8] = {8{pk[b]}};
    end

    // Payload lands directly behind the r residue bytes in a 2N-byte window.
    assign pay_ext = {{DATA_WD{1'b0}}, data_in & pay_mask};
    assign win     = {res_q, {DATA_WD{1'b0}}} | (pay_ext << (8 * (NumBytes - 32'(r_q))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            res_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            r_q     <= r_d;
            err_q   <= err_d;
            if (valid_out && ready_out && last_out) pkt_q <= pkt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (acc_hdr) state_d = StStream;
            StStream: begin
                if (acc_pay && last_in) begin
                    if (k_cnt == '0) state_d = (r_q != '0) ? StFlush : StIdle;
                    else             state_d = (r_after != '0) ? StFlush : StIdle;
                end
            end
            StFlush:  if (adv) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_keep  = '0;
        ld_last  = 1'b0;
        res_d    = res_q;
        r_d      = r_q;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_hdr) begin
                    res_d = (data_insert & hdr_mask) << (8 * (NumBytes - 32'(h_cnt)));
                    r_d   = h_cnt;
                    err_d = hdr_bad;
                end
            end
            StStream: begin
                if (acc_pay) begin
                    err_d = pay_bad;
                    if (k_cnt == '0) begin
                        // Empty last beat with no residue still closes the packet.
                        if (last_in && (r_q == '0)) begin
                            ld_valid = 1'b1;
                            ld_last  = 1'b1;
                        end
                    end else if (t_cnt >= NFull) begin
                        ld_valid = 1'b1;
                        ld_data  = win[WinWd-1 -: DATA_WD];
                        ld_keep  = '1;
                        ld_last  = last_in && (r_after == '0);
                        res_d    = win[DATA_WD-1:0];
                        r_d      = r_after;
                    end else begin
                        ld_valid = 1'b1;
                        ld_data  = win[WinWd-1 -: DATA_WD];
                        ld_keep  = tk;
                        ld_last  = last_in;
                        res_d    = '0;
                        r_d      = '0;
                    end
                end
            end
            StFlush: begin
                if (adv) begin
                    ld_valid = 1'b1;
                    ld_data  = res_q;
                    ld_keep  = rk;
                    ld_last  = 1'b1;
                    res_d    = '0;
                    r_d      = '0;
                end
            end
            default: ;
        endcase
    end

    axis_out_slice #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .load_valid (ld_valid),
        .load_data  (ld_data),
        .load_keep  (ld_keep),
        .load_last  (ld_last),
        .adv        (adv),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .keep_out   (keep_out),
        .last_out   (last_out),
        .ready_out  (ready_out)
    );

    assign err_keep = err_q;
    assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_axis_header_merge_packer.sv
// Directed bench for the header merge packer at 32-bit width with hand-computed beats.
module tb_axis_header_merge_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [3:0]  keep_insert = '0;
    logic        ready_insert;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
    logic        err_keep;
    logic [15:0] pkt_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    err_cnt = 0;
    int    ro_mode = 0;
    int    err_base;

    axis_header_merge_packer #(
        .DATA_WD    (32),
        .PKT_CNT_WD (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .ready_insert (ready_insert),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .err_keep     (err_keep),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // ready_out pattern: 0 = always ready, 1 = toggle each cycle, 2 = held low.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ro_mode)
                1:       ready_out = ~ready_out;
                2:       ready_out = 1'b0;
                default: ready_out = 1'b1;
            endcase
        end
    end

    // Monitor: collect accepted beats, count err pulses, check stability while stalled.
    initial begin
        beat_t b;
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 64'(valid_out), 64'(1));
                check("hold_data", 64'(data_out), 64'(prev.d));
                check("hold_keep", 64'(keep_out), 64'(prev.k));
                check("hold_last", 64'(last_out), 64'(prev.l));
            end
            if (valid_out && ready_out) begin
                b.d = data_out;
                b.k = keep_out;
                b.l = last_out;
                got_q.push_back(b);
            end
            if (err_keep) err_cnt++;
            prev_stall = valid_out && !ready_out && !rst;
            prev.d = data_out;
            prev.k = keep_out;
            prev.l = last_out;
        end
    end

    task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
        int t;
        t = 0;
        valid_insert = 1'b1;
        data_insert  = d;
        keep_insert  = k;
        @(negedge clk);
        while (!ready_insert && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("hdr_accept", 64'(ready_insert), 64'(1));
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        @(negedge clk);
        while (!ready_in && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("beat_accept", 64'(ready_in), 64'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int pc_exp);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_data%0d", name, i), 64'(got_q[i].d & bmask(got_q[i].k)),
                      64'(exp_q[i].d & bmask(exp_q[i].k)));
                check($sformatf("%s_keep%0d", name, i), 64'(got_q[i].k), 64'(exp_q[i].k));
                check($sformatf("%s_last%0d", name, i), 64'(got_q[i].l), 64'(exp_q[i].l));
            end
        end
        check({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(pc_exp));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_t1(input string name, input int pc_exp);
        err_base = err_cnt;
        expect_beat(32'hAABBCCCC, 4'b1111, 1'b0);
        expect_beat(32'hCCCCDDDD, 4'b1111, 1'b0);
        expect_beat(32'hDDDDEEEE, 4'b1111, 1'b1);
        send_hdr(32'h0000AABB, 4'b0011);
        send_beat(32'hCCCCCCCC, 4'b1111, 1'b0);
        send_beat(32'hDDDDDDDD, 4'b1111, 1'b0);
        send_beat(32'hEEEE0000, 4'b1100, 1'b1);
        drain(name, pc_exp);
        check({name, "_no_err"}, 64'(err_cnt - err_base), 64'(0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_keep_out", 64'(keep_out), 64'(0));
        check("rst_last_out", 64'(last_out), 64'(0));
        check("rst_err_keep", 64'(err_keep), 64'(0));
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        check("rst_ready_insert", 64'(ready_insert), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_ready_insert", 64'(ready_insert), 64'(1));
        check("idle_ready_in", 64'(ready_in), 64'(0));

        // 1: two-byte header, three-beat packet
        run_t1("t1", 1);

        // 2: three-byte header overflows into a FLUSH beat
        expect_beat(32'hAABBCC11, 4'b1111, 1'b0);
        expect_beat(32'h11111122, 4'b1111, 1'b0);
        expect_beat(32'h22220000, 4'b1100, 1'b1);
        send_hdr(32'h00AABBCC, 4'b0111);
        send_beat(32'h11111111, 4'b1111, 1'b0);
        send_beat(32'h22222200, 4'b1110, 1'b1);
        drain("t2", 2);

        // 3: empty header, pass-through with one cycle latency
        expect_beat(32'h01020304, 4'b1111, 1'b0);
        expect_beat(32'h05060700, 4'b1110, 1'b1);
        send_hdr(32'h12345678, 4'b0000);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        check("t3_latency_valid", 64'(valid_out), 64'(1));
        check("t3_latency_data", 64'(data_out), 64'(32'h01020304));
        send_beat(32'h05060700, 4'b1110, 1'b1);
        drain("t3", 3);

        // 4: test 1 again with downstream toggling ready
        ro_mode = 1;
        run_t1("t4", 4);
        ro_mode = 0;

        // 5a: non-contiguous header keep counts as H=1 and flags an error
        err_base = err_cnt;
        expect_beat(32'h44556677, 4'b1111, 1'b0);
        expect_beat(32'h88000000, 4'b1000, 1'b1);
        send_hdr(32'h11223344, 4'b0101);
        check("t5_err_pulse", 64'(err_keep), 64'(1));
        send_beat(32'h55667788, 4'b1111, 1'b1);
        drain("t5a", 5);
        check("t5a_err_count", 64'(err_cnt - err_base), 64'(1));

        // 5b: full-width header goes out as its own beat
        err_base = err_cnt;
        expect_beat(32'h99AABBCC, 4'b1111, 1'b0);
        expect_beat(32'h01020304, 4'b1111, 1'b0);
        expect_beat(32'h05060708, 4'b1111, 1'b1);
        send_hdr(32'h99AABBCC, 4'b1111);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        drain("t5b", 6);
        check("t5b_err_count", 64'(err_cnt - err_base), 64'(0));

        // 6: reset while a FLUSH beat is pending
        ro_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_hdr(32'h00112233, 4'b0111);
        send_beat(32'h44556677, 4'b1111, 1'b1);
        @(negedge clk);
        check("t6_stalled_valid", 64'(valid_out), 64'(1));
        check("t6_flush_no_hdr", 64'(ready_insert), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_ready_in", 64'(ready_in), 64'(0));
        check("t6_rst_ready_insert", 64'(ready_insert), 64'(0));
        @(posedge clk);
        #1;
        check("t6_rst_valid_out", 64'(valid_out), 64'(0));
        check("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        rst = 1'b0;
        ro_mode = 0;
        #1;
        check("t6_ready_insert", 64'(ready_insert), 64'(1));
        check("t6_no_stale_beats", 64'(got_q.size()), 64'(0));
        got_q.delete();
        expect_beat(32'hAB010203, 4'b1111, 1'b0);
        expect_beat(32'h04000000, 4'b1000, 1'b1);
        send_hdr(32'h000000AB, 4'b0001);
        send_beat(32'h01020304, 4'b1111, 1'b1);
        drain("t6", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
